// File: rtl/nn_pkg.sv
// Shared fixed-point defaults and FSM state encoding for the nn training datapath.
package nn_pkg;

  localparam int NN_WIDTH = 32;
  localparam int NN_FRAC  = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HID  = 2'd1,
    ST_OUT  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [NN_WIDTH-1:0] NN_SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [NN_WIDTH-1:0] NN_SAT_MIN = 32'h8000_0000;

endpackage

// File: rtl/fx_mul_sat.sv
// Signed fixed-point multiply: full-width product, arithmetic shift by FRAC,
// then clamp back into WIDTH bits.
module fx_mul_sat #(
  parameter int WIDTH = nn_pkg::NN_WIDTH,
  parameter int FRAC  = nn_pkg::NN_FRAC
) (
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  output logic signed [WIDTH-1:0] o_y
);

  localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] a_ext;
  logic signed [2*WIDTH-1:0] b_ext;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] shifted;

  always_comb begin
    a_ext   = {{WIDTH{i_a[WIDTH-1]}}, i_a};
    b_ext   = {{WIDTH{i_b[WIDTH-1]}}, i_b};
    prod    = a_ext * b_ext;
    shifted = prod >>> FRAC;
    // Result fits when every bit above the WIDTH-1 sign bit matches it.
    if ((shifted[2*WIDTH-1:WIDTH-1] == {(WIDTH+1){1'b0}}) ||
        (shifted[2*WIDTH-1:WIDTH-1] == {(WIDTH+1){1'b1}})) begin
      o_y = shifted[WIDTH-1:0];
    end else if (shifted[2*WIDTH-1]) begin
      o_y = SAT_MIN;
    end else begin
      o_y = SAT_MAX;
    end
  end

endmodule

// File: rtl/wupdate_nn.sv
// Serial gradient-descent weight update: one weight per clock, hidden layer
// first, then output layer, through a chained delta*act then lr*g multiply path.
module wupdate_nn
  import nn_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int N_HL_P = 3,
  parameter int N_OUT  = 2,
  parameter int WIDTH  = NN_WIDTH,
  parameter int FRAC   = NN_FRAC
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_start,
  input  logic [WIDTH-1:0]                i_lr,
  input  logic [N_IN*WIDTH-1:0]           i_in_a,
  input  logic [N_HL_P*WIDTH-1:0]         i_hd_a,
  input  logic [N_HL_P*WIDTH-1:0]         i_dlth,
  input  logic [N_OUT*WIDTH-1:0]          i_dlto,
  input  logic [N_HL_P*N_IN*WIDTH-1:0]    i_hd_w,
  input  logic [N_HL_P*N_OUT*WIDTH-1:0]   i_out_w,
  output logic [N_HL_P*N_IN*WIDTH-1:0]    o_hd_w,
  output logic [N_HL_P*N_OUT*WIDTH-1:0]   o_out_w,
  output logic                            o_busy,
  output logic                            o_done
);

  localparam int NH   = N_HL_P * N_IN;
  localparam int NO   = N_HL_P * N_OUT;
  localparam int HW   = (N_HL_P > 1) ? $clog2(N_HL_P) : 1;
  localparam int KMAX = (N_IN > N_OUT) ? N_IN : N_OUT;
  localparam int KW   = (KMAX > 1) ? $clog2(KMAX) : 1;

  localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Handshake: i_start is a request with no ready; it is accepted only in
  // IDLE, and requests arriving while busy or in DONE are dropped, not queued.

  state_e                    state_q, state_d;
  logic [HW-1:0]             h_q, h_d;
  logic [KW-1:0]             k_q, k_d;
  logic [WIDTH-1:0]          lr_q, lr_d;
  logic [N_IN*WIDTH-1:0]     in_a_q, in_a_d;
  logic [N_HL_P*WIDTH-1:0]   hd_a_q, hd_a_d;
  logic [N_HL_P*WIDTH-1:0]   dlth_q, dlth_d;
  logic [N_OUT*WIDTH-1:0]    dlto_q, dlto_d;
  logic [NH*WIDTH-1:0]       hd_w_q, hd_w_d;
  logic [NO*WIDTH-1:0]       out_w_q, out_w_d;

  logic signed [WIDTH-1:0]   delta_sel, act_sel, w_old, g, s, w_new;
  logic signed [WIDTH:0]     diff;
  int                        hd_slot, out_slot;

  // Element mux: k walks i in HID and o in OUT.
  always_comb begin
    hd_slot   = int'(h_q) * N_IN + int'(k_q);
    out_slot  = int'(h_q) * N_OUT + int'(k_q);
    delta_sel = '0;
    act_sel   = '0;
    w_old     = '0;
    if (state_q == ST_OUT) begin
      for (int o = 0; o < N_OUT; o++)
        if (int'(k_q) == o) delta_sel = dlto_q[o*WIDTH +: WIDTH];
      for (int h = 0; h < N_HL_P; h++)
        if (int'(h_q) == h) act_sel = hd_a_q[h*WIDTH +: WIDTH];
      for (int j = 0; j < NO; j++)
        if (j == out_slot) w_old = out_w_q[j*WIDTH +: WIDTH];
    end else begin
      for (int h = 0; h < N_HL_P; h++)
        if (int'(h_q) == h) delta_sel = dlth_q[h*WIDTH +: WIDTH];
      for (int i = 0; i < N_IN; i++)
        if (int'(k_q) == i) act_sel = in_a_q[i*WIDTH +: WIDTH];
      for (int j = 0; j < NH; j++)
        if (j == hd_slot) w_old = hd_w_q[j*WIDTH +: WIDTH];
    end
  end

  fx_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_da (
    .i_a (delta_sel),
    .i_b (act_sel),
    .o_y (g)
  );

  fx_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_lr (
    .i_a (lr_q),
    .i_b (g),
    .o_y (s)
  );

  always_comb begin
    diff = {w_old[WIDTH-1], w_old} - {s[WIDTH-1], s};
    if (diff[WIDTH] != diff[WIDTH-1]) w_new = diff[WIDTH] ? SAT_MIN : SAT_MAX;
    else                              w_new = diff[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    k_d     = k_q;
    lr_d    = lr_q;
    in_a_d  = in_a_q;
    hd_a_d  = hd_a_q;
    dlth_d  = dlth_q;
    dlto_d  = dlto_q;
    hd_w_d  = hd_w_q;
    out_w_d = out_w_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          lr_d    = i_lr;
          in_a_d  = i_in_a;
          hd_a_d  = i_hd_a;
          dlth_d  = i_dlth;
          dlto_d  = i_dlto;
          hd_w_d  = i_hd_w;
          out_w_d = i_out_w;
          h_d     = '0;
          k_d     = '0;
          state_d = ST_HID;
        end
      end
      ST_HID: begin
        for (int j = 0; j < NH; j++)
          if (j == hd_slot) hd_w_d[j*WIDTH +: WIDTH] = w_new;
        if (k_q == KW'(N_IN - 1)) begin
          k_d = '0;
          if (h_q == HW'(N_HL_P - 1)) begin
            h_d     = '0;
            state_d = ST_OUT;
          end else begin
            h_d = h_q + HW'(1);
          end
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ST_OUT: begin
        for (int j = 0; j < NO; j++)
          if (j == out_slot) out_w_d[j*WIDTH +: WIDTH] = w_new;
        if (k_q == KW'(N_OUT - 1)) begin
          k_d = '0;
          if (h_q == HW'(N_HL_P - 1)) begin
            h_d     = '0;
            state_d = ST_DONE;
          end else begin
            h_d = h_q + HW'(1);
          end
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      k_q     <= '0;
      lr_q    <= '0;
      in_a_q  <= '0;
      hd_a_q  <= '0;
      dlth_q  <= '0;
      dlto_q  <= '0;
      hd_w_q  <= '0;
      out_w_q <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      k_q     <= k_d;
      lr_q    <= lr_d;
      in_a_q  <= in_a_d;
      hd_a_q  <= hd_a_d;
      dlth_q  <= dlth_d;
      dlto_q  <= dlto_d;
      hd_w_q  <= hd_w_d;
      out_w_q <= out_w_d;
    end
  end

  assign o_hd_w  = hd_w_q;
  assign o_out_w = out_w_q;
  assign o_busy  = (state_q != ST_IDLE);
  assign o_done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_wupdate_nn.sv
// Directed bench for wupdate_nn: hand-computed Q8.24 weight updates, timing,
// ignored starts, mid-pass reset and zero learning rate.
module tb_wupdate_nn;

  localparam int N_IN   = 2;
  localparam int N_HL_P = 3;
  localparam int N_OUT  = 2;
  localparam int WIDTH  = 32;
  localparam int NH     = N_HL_P * N_IN;
  localparam int NO     = N_HL_P * N_OUT;
  localparam logic [WIDTH-1:0] ONE  = 32'h0100_0000;
  localparam logic [WIDTH-1:0] HALF = 32'h0080_0000;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      i_start;
  logic [WIDTH-1:0]          i_lr;
  logic [N_IN*WIDTH-1:0]     i_in_a;
  logic [N_HL_P*WIDTH-1:0]   i_hd_a;
  logic [N_HL_P*WIDTH-1:0]   i_dlth;
  logic [N_OUT*WIDTH-1:0]    i_dlto;
  logic [NH*WIDTH-1:0]       i_hd_w;
  logic [NO*WIDTH-1:0]       i_out_w;
  logic [NH*WIDTH-1:0]       o_hd_w;
  logic [NO*WIDTH-1:0]       o_out_w;
  logic                      o_busy;
  logic                      o_done;

  int n_checks = 0;
  int n_pass   = 0;
  logic [WIDTH-1:0] exp_q[$];

  wupdate_nn #(.N_IN(N_IN), .N_HL_P(N_HL_P), .N_OUT(N_OUT), .WIDTH(WIDTH), .FRAC(24)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (i_start),
    .i_lr    (i_lr),
    .i_in_a  (i_in_a),
    .i_hd_a  (i_hd_a),
    .i_dlth  (i_dlth),
    .i_dlto  (i_dlto),
    .i_hd_w  (i_hd_w),
    .i_out_w (i_out_w),
    .o_hd_w  (o_hd_w),
    .o_out_w (o_out_w),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Scoreboard: expected hidden slots then output slots, in packing order.
  task automatic check_weights(input string tag);
    for (int j = 0; j < NH; j++)
      check($sformatf("%s hd_w[%0d]", tag, j), o_hd_w[j*WIDTH +: WIDTH], exp_q.pop_front());
    for (int j = 0; j < NO; j++)
      check($sformatf("%s out_w[%0d]", tag, j), o_out_w[j*WIDTH +: WIDTH], exp_q.pop_front());
  endtask

  // ---------------- drivers ----------------
  task automatic set_uniform(input logic [WIDTH-1:0] dh, input logic [WIDTH-1:0] dout,
                             input logic [WIDTH-1:0] a_in, input logic [WIDTH-1:0] a_hd,
                             input logic [WIDTH-1:0] lr, input logic [WIDTH-1:0] w_h,
                             input logic [WIDTH-1:0] w_o);
    i_lr = lr;
    for (int i = 0; i < N_IN; i++)   i_in_a[i*WIDTH +: WIDTH] = a_in;
    for (int h = 0; h < N_HL_P; h++) i_hd_a[h*WIDTH +: WIDTH] = a_hd;
    for (int h = 0; h < N_HL_P; h++) i_dlth[h*WIDTH +: WIDTH] = dh;
    for (int o = 0; o < N_OUT; o++)  i_dlto[o*WIDTH +: WIDTH] = dout;
    for (int j = 0; j < NH; j++)     i_hd_w[j*WIDTH +: WIDTH] = w_h;
    for (int j = 0; j < NO; j++)     i_out_w[j*WIDTH +: WIDTH] = w_o;
  endtask

  task automatic push_uniform(input logic [WIDTH-1:0] e_h, input logic [WIDTH-1:0] e_o);
    for (int j = 0; j < NH; j++) exp_q.push_back(e_h);
    for (int j = 0; j < NO; j++) exp_q.push_back(e_o);
  endtask

  // Pulses start in an IDLE cycle, checks busy in cycle 1, the o_done cycle,
  // and that the block is idle the cycle after. Returns in the o_done cycle + 1.
  task automatic run_pass(input string tag);
    int done_cyc;
    @(negedge clk);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start  = 1'b0;
    done_cyc = -1;
    check({tag, " busy c1"}, {31'd0, o_busy}, 32'd1);
    for (int c = 1; c <= 40; c++) begin
      if (o_done) begin
        done_cyc = c;
        break;
      end
      @(posedge clk); #1;
    end
    check({tag, " done cycle"}, done_cyc, 32'd13);
    check_weights(tag);
    @(posedge clk); #1;
    check({tag, " idle after done"}, {31'd0, o_busy}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int done_cnt;
    int done_at;
    rst_n   = 1'b0;
    i_start = 1'b0;
    set_uniform('0, '0, '0, '0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {31'd0, o_busy}, 32'd0);
    check("reset done", {31'd0, o_done}, 32'd0);
    push_uniform(32'h0, 32'h0);
    check_weights("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic: 1.0 - 1.0*(0.5*0.5) = 0.75
    set_uniform(HALF, HALF, HALF, HALF, ONE, ONE, ONE);
    push_uniform(32'h00C0_0000, 32'h00C0_0000);
    run_pass("basic");

    // Index mapping: weight 0, activations 1.0, delta scaled by index
    set_uniform('0, '0, ONE, ONE, ONE, '0, '0);
    for (int h = 0; h < N_HL_P; h++) i_dlth[h*WIDTH +: WIDTH] = (h + 1) * 32'h0010_0000;
    for (int o = 0; o < N_OUT; o++)  i_dlto[o*WIDTH +: WIDTH] = (o + 1) * 32'h0010_0000;
    for (int h = 0; h < N_HL_P; h++)
      for (int i = 0; i < N_IN; i++) exp_q.push_back(-((h + 1) * 32'h0010_0000));
    for (int h = 0; h < N_HL_P; h++)
      for (int o = 0; o < N_OUT; o++) exp_q.push_back(-((o + 1) * 32'h0010_0000));
    run_pass("index");

    // Subtraction saturation: hidden clamps high, output clamps low
    set_uniform(32'hFF00_0000, ONE, ONE, ONE, ONE, 32'h7FF0_0000, 32'h8010_0000);
    push_uniform(32'h7FFF_FFFF, 32'h8000_0000);
    run_pass("sub_sat");

    // Multiplier saturation: g clamps to max (hidden) and min (output)
    set_uniform(32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, ONE, '0, '0);
    push_uniform(32'h8000_0001, 32'h7FFF_FFFF);
    run_pass("mul_sat");

    // Starts while busy are ignored; results come from the cycle-0 snapshot
    set_uniform(HALF, HALF, HALF, HALF, ONE, ONE, ONE);
    @(negedge clk);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    set_uniform(ONE, ONE, ONE, ONE, ONE, 32'h1234_5678, 32'h1234_5678);
    done_cnt = 0;
    done_at  = -1;
    for (int c = 1; c <= 20; c++) begin
      if (o_done) begin
        done_cnt++;
        done_at = c;
      end
      if (c == 14) check("busy_start idle c14", {31'd0, o_busy}, 32'd0);
      i_start = (c == 3 || c == 13);
      @(posedge clk); #1;
    end
    i_start = 1'b0;
    check("busy_start done count", done_cnt, 32'd1);
    check("busy_start done cycle", done_at, 32'd13);
    push_uniform(32'h00C0_0000, 32'h00C0_0000);
    check_weights("busy_start");

    // Mid-pass reset clears everything asynchronously
    set_uniform(HALF, HALF, HALF, HALF, ONE, 32'h0300_0000, 32'h0300_0000);
    @(negedge clk);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("rst pre busy", {31'd0, o_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst busy", {31'd0, o_busy}, 32'd0);
    check("rst done", {31'd0, o_done}, 32'd0);
    push_uniform(32'h0, 32'h0);
    check_weights("rst");
    @(negedge clk);
    rst_n = 1'b1;
    set_uniform(HALF, HALF, HALF, HALF, ONE, ONE, ONE);
    push_uniform(32'h00C0_0000, 32'h00C0_0000);
    run_pass("after_rst");

    // Zero learning rate leaves weights bit-exact
    set_uniform(32'h1234_5678, 32'hF0F0_0000, 32'h0345_6789, 32'h7000_0000, '0, '0, '0);
    for (int j = 0; j < NH; j++) begin
      i_hd_w[j*WIDTH +: WIDTH] = 32'h0ABC_0000 + j;
      exp_q.push_back(32'h0ABC_0000 + j);
    end
    for (int j = 0; j < NO; j++) begin
      i_out_w[j*WIDTH +: WIDTH] = 32'hF123_4560 - j;
      exp_q.push_back(32'hF123_4560 - j);
    end
    run_pass("zero_lr");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wupdate_nn.md
# wupdate_nn

Weight-update stage directly downstream of `delta_nn`. It consumes the hidden and output deltas (`o_dlth`, `o_dlto`) together with the forward activations and the current weights. It applies one gradient-descent step, w ← w − lr·δ·a, to every hidden-layer and output-layer weight. The update runs serially, one weight per clock, through a single chained fixed-point multiply path, and `o_done` pulses when both updated weight vectors are complete.

## Interface
- `N_IN`, 2, number of network inputs
- `N_HL_P`, 3, number of hidden perceptrons
- `N_OUT`, 2, number of output perceptrons
- `WIDTH`, 32, signed fixed-point word width
- `FRAC`, 24, fraction bits (Q8.24; 1.0 = 0x01000000)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `i_start`  in  1  request an update pass; sampled only in IDLE
- `i_lr`  in  WIDTH  learning rate
- `i_in_a`  in  N_IN*WIDTH  network input activations, element i at `[i*WIDTH +: WIDTH]`
- `i_hd_a`  in  N_HL_P*WIDTH  hidden activations, element h
- `i_dlth`  in  N_HL_P*WIDTH  hidden deltas, element h
- `i_dlto`  in  N_OUT*WIDTH  output deltas, element o
- `i_hd_w`  in  N_HL_P*N_IN*WIDTH  hidden weights, index h*N_IN+i
- `i_out_w`  in  N_HL_P*N_OUT*WIDTH  output weights, index h*N_OUT+o (same packing as `delta_nn` `i_out_w`)
- `o_hd_w`  out  N_HL_P*N_IN*WIDTH  updated hidden weights, same packing
- `o_out_w`  out  N_HL_P*N_OUT*WIDTH  updated output weights, same packing
- `o_busy`  out  1  high in HID, OUT and DONE
- `o_done`  out  1  one-cycle pulse when the pass is complete

## Operation
- **States:**
  - IDLE: wait for `i_start`.
  - HID: walk h = 0..N_HL_P−1 and, inside each h, i = 0..N_IN−1.
  - OUT: walk h = 0..N_HL_P−1 and, inside each h, o = 0..N_OUT−1.
  - DONE: assert `o_done` for one cycle, then return to IDLE.
- **Start:** when IDLE and `i_start`=1, snapshot all inputs (`i_lr`, activations, deltas, weights) into internal registers, load `o_hd_w`/`o_out_w` with the snapshot weights, clear the indices, and go to HID. Inputs may change freely afterwards.
- **HID element:**
  - g = sat((δh[h]·a_in[i]) >>> FRAC)
  - s = sat((lr·g) >>> FRAC)
  - w' = sat(w − s), written to slot h*N_IN+i.
- **OUT element:** same computation with δo[o], a_hd[h] and slot h*N_OUT+o.
- **Arithmetic:**
  - Products are full 2·WIDTH signed.
  - `>>>` is an arithmetic shift, truncating toward −∞.
  - sat() clamps to [0x80000000, 0x7FFFFFFF] for WIDTH=32 (generally −2^(WIDTH−1) .. 2^(WIDTH−1)−1).
  - The subtraction is computed in WIDTH+1 bits, then clamped.
- **Ignored start:** `i_start` in any state other than IDLE is ignored and is not queued.
- **Outputs during a pass:** `o_hd_w`/`o_out_w` are partially updated while busy. They are valid from the `o_done` cycle onward and hold until the next accepted start.

## Timing
- Cycle 0 is the cycle in which `i_start` is sampled high in IDLE.
- HID occupies cycles 1..N_HL_P·N_IN. Each element is written at the end of its cycle.
- OUT occupies the next N_HL_P·N_OUT cycles.
- `o_done`=1 in cycle N_HL_P·(N_IN+N_OUT)+1 (cycle 13 with defaults). The weight outputs are final in that cycle.
- The block is back in IDLE the following cycle and can accept `i_start` in that cycle. No back-to-back start on the DONE cycle.
- **Reset values:**
  - `o_hd_w`=0, `o_out_w`=0, `o_busy`=0, `o_done`=0
  - state=IDLE, indices=0, snapshot registers=0
- **Reset mid-pass:** aborts immediately and asynchronously. No partial result is retained.

## Structure
- **Shared package `nn_pkg`:**
  - WIDTH and FRAC defaults
  - state enum (IDLE, HID, OUT, DONE)
  - saturation limit constants
- **Sub-module `fx_mul_sat`:** signed WIDTH×WIDTH multiply, `>>>` FRAC, then saturate to WIDTH. Instantiated twice, chained as δ·a then lr·g.
- **Remainder:** FSM, index counters, element mux and write-back.

## Test plan
- **Basic update:** all δ=0x00800000 (0.5), all activations 0x00800000, lr=0x01000000, all weights 0x01000000, start → `o_done` at cycle 13; every weight = 0x00C00000.
- **Index mapping:** δh[h]=(h+1)·0x00100000, all activations 1.0, lr 1.0, weights 0 → hidden slot h*N_IN+i = −(h+1)·0x00100000. With δo[o]=(o+1)·0x00100000, output slot h*N_OUT+o = −(o+1)·0x00100000.
- **Saturation:** w=0x7FF00000, δ=0xFF000000 (−1.0), a=1.0, lr=1.0 → 0x7FFFFFFF. Separately, w=0x80100000, δ=+1.0, a=1.0, lr=1.0 → 0x80000000.
- **Start while busy:** `i_start` pulsed at cycles 3 and 13, inputs changed after cycle 0 → single `o_done` at cycle 13; results reflect the cycle-0 snapshot; IDLE at cycle 14.
- **Reset mid-pass:** `rst_n` low at cycle 6 → `o_busy`, `o_done` and all weights are 0 immediately; after release, a fresh start completes normally 13 cycles later.
- **Zero learning rate:** lr=0, arbitrary δ and activations → outputs equal input weights bit-exactly.
